// File: rtl/i2c_cmd_arbiter.sv
// Round-robin arbiter sharing one FIFO-fronted I2C master among NUM_REQ requesters.
// In-order tag FIFOs route read bytes and write-success strobes back to the issuing requester.
module i2c_cmd_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int TAG_DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [56*NUM_REQ-1:0]        req_cmd,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [7:0]                   rsp_rdata,
    output logic [NUM_REQ-1:0]           rsp_rdata_valid,
    output logic [NUM_REQ-1:0]           rsp_wr_success,
    output logic [55:0]                  i2c_fifo_din,
    output logic                         i2c_fifo_wr_en,
    input  logic                         i2c_fifo_full,
    input  logic [7:0]                   i2c_rdata,
    input  logic                         i2c_rdata_valid,
    input  logic                         i2c_wr_data_success,
    input  logic                         tag_flush,
    output logic [$clog2(TAG_DEPTH):0]   rd_outstanding,
    output logic [$clog2(TAG_DEPTH):0]   wr_outstanding,
    output logic                         err_orphan
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int AW    = $clog2(TAG_DEPTH);
    localparam int PTR_W = AW + 1;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);

    function automatic logic [NUM_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

    logic [PTR_W-1:0] rd_wptr_r, rd_rptr_r, wr_wptr_r, wr_rptr_r;
    logic [PTR_W-1:0] rd_wptr_nxt_s, rd_rptr_nxt_s, wr_wptr_nxt_s, wr_rptr_nxt_s;
    logic [IDX_W-1:0] rd_mem_r [TAG_DEPTH];
    logic [IDX_W-1:0] wr_mem_r [TAG_DEPTH];
    logic [IDX_W-1:0] last_grant_r, win_idx_s, rd_tag_s, wr_tag_s;
    logic [NUM_REQ-1:0] eligible_s;
    logic [55:0]      win_cmd_s;
    logic             rd_empty_s, rd_full_s, wr_empty_s, wr_full_s;
    logic             grant_ok_s, found_s, grant_s, win_rw_s;
    logic             rd_push_s, wr_push_s, rd_pop_s, wr_pop_s, orphan_s;

    // Tag FIFO status: the extra pointer MSB separates full from empty
    always_comb begin
        rd_empty_s = (rd_wptr_r == rd_rptr_r);
        wr_empty_s = (wr_wptr_r == wr_rptr_r);
        rd_full_s  = (rd_wptr_r[AW] != rd_rptr_r[AW]) && (rd_wptr_r[AW-1:0] == rd_rptr_r[AW-1:0]);
        wr_full_s  = (wr_wptr_r[AW] != wr_rptr_r[AW]) && (wr_wptr_r[AW-1:0] == wr_rptr_r[AW-1:0]);
        rd_tag_s   = rd_mem_r[rd_rptr_r[AW-1:0]];
        wr_tag_s   = wr_mem_r[wr_rptr_r[AW-1:0]];
    end

    // Eligibility: a full tag FIFO blocks only commands of its own type
    always_comb begin
        grant_ok_s = !i2c_fifo_full && !i2c_fifo_wr_en && !tag_flush && rstn;
        eligible_s = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_cmd[56*i+48]) begin
                eligible_s[i] = req_valid[i] && !rd_full_s;
            end else begin
                eligible_s[i] = req_valid[i] && !wr_full_s;
            end
        end
    end

    // Round-robin search starting just after the previous winner
    always_comb begin
        int               cand_v;
        logic [IDX_W-1:0] cand_idx;
        found_s   = 1'b0;
        win_idx_s = last_grant_r;
        cand_v    = 0;
        cand_idx  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand_v = int'(last_grant_r) + k;
            if (cand_v >= NUM_REQ) begin
                cand_v = cand_v - NUM_REQ;
            end else begin
                cand_v = cand_v;
            end
            cand_idx = IDX_W'(cand_v);
            if (!found_s && eligible_s[cand_idx]) begin
                found_s   = 1'b1;
                win_idx_s = cand_idx;
            end else begin
                found_s   = found_s;
            end
        end
    end

    // Winner command mux and push/pop/orphan decisions
    always_comb begin
        win_cmd_s = 56'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == win_idx_s) begin
                win_cmd_s = req_cmd[56*i +: 56];
            end else begin
                win_cmd_s = win_cmd_s;
            end
        end
        grant_s   = grant_ok_s && found_s;
        req_ready = grant_s ? idx_onehot(win_idx_s) : '0;
        win_rw_s  = win_cmd_s[48];
        rd_push_s = grant_s && win_rw_s;
        wr_push_s = grant_s && !win_rw_s;
        rd_pop_s  = i2c_rdata_valid && !rd_empty_s && !tag_flush;
        wr_pop_s  = i2c_wr_data_success && !wr_empty_s && !tag_flush;
        orphan_s  = (i2c_rdata_valid && (rd_empty_s || tag_flush)) ||
                    (i2c_wr_data_success && (wr_empty_s || tag_flush));
        rd_wptr_nxt_s = tag_flush ? '0 : rd_wptr_r + PTR_W'(rd_push_s);
        rd_rptr_nxt_s = tag_flush ? '0 : rd_rptr_r + PTR_W'(rd_pop_s);
        wr_wptr_nxt_s = tag_flush ? '0 : wr_wptr_r + PTR_W'(wr_push_s);
        wr_rptr_nxt_s = tag_flush ? '0 : wr_rptr_r + PTR_W'(wr_pop_s);
    end

    // Tag storage carries no reset; the pointers alone define its contents
    always_ff @(posedge clk) begin
        if (rd_push_s) rd_mem_r[rd_wptr_r[AW-1:0]] <= win_idx_s;
        if (wr_push_s) wr_mem_r[wr_wptr_r[AW-1:0]] <= win_idx_s;
    end

    // Pointers, occupancy, master write port and response pulses
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_wptr_r       <= '0;
            rd_rptr_r       <= '0;
            wr_wptr_r       <= '0;
            wr_rptr_r       <= '0;
            rd_outstanding  <= '0;
            wr_outstanding  <= '0;
            last_grant_r    <= LAST_RST;
            i2c_fifo_wr_en  <= 1'b0;
            i2c_fifo_din    <= 56'd0;
            rsp_rdata       <= 8'd0;
            rsp_rdata_valid <= '0;
            rsp_wr_success  <= '0;
            err_orphan      <= 1'b0;
        end else begin
            rd_wptr_r       <= rd_wptr_nxt_s;
            rd_rptr_r       <= rd_rptr_nxt_s;
            wr_wptr_r       <= wr_wptr_nxt_s;
            wr_rptr_r       <= wr_rptr_nxt_s;
            rd_outstanding  <= rd_wptr_nxt_s - rd_rptr_nxt_s;
            wr_outstanding  <= wr_wptr_nxt_s - wr_rptr_nxt_s;
            i2c_fifo_wr_en  <= grant_s;
            if (grant_s) begin
                i2c_fifo_din <= win_cmd_s;
                last_grant_r <= win_idx_s;
            end
            if (rd_pop_s) rsp_rdata <= i2c_rdata;
            rsp_rdata_valid <= rd_pop_s ? idx_onehot(rd_tag_s) : '0;
            rsp_wr_success  <= wr_pop_s ? idx_onehot(wr_tag_s) : '0;
            err_orphan      <= orphan_s;
        end
    end

endmodule
